// File: rtl/poc_pkg.sv
// Shared PoC definitions: beat geometry, run limits, the fixed data pattern and checker state encodings.
package poc_pkg;

  localparam int nCK_PER_CLK    = 4;
  localparam int DQ_WIDTH       = 64;
  localparam int BEAT_W         = 2 * nCK_PER_CLK * DQ_WIDTH;
  localparam int EXP_BEATS      = 128;
  localparam int TIMEOUT_CYCLES = 1023;

  localparam int IDX_W   = 7;
  localparam int CNT_W   = 8;
  localparam int STRAY_W = 4;
  localparam int TMR_W   = 10;

  // Bytes 0x00..0x3f with 0x00 in the most significant byte.
  localparam logic [BEAT_W-1:0] PATTERN = {
    128'h000102030405060708090a0b0c0d0e0f,
    128'h101112131415161718191a1b1c1d1e1f,
    128'h202122232425262728292a2b2c2d2e2f,
    128'h303132333435363738393a3b3c3d3e3f
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CHECK,
    ST_DONE,
    ST_TOUT
  } rdchk_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/poc_rddata_checker_if.sv
// PHY read-data bus: the PHY is the master, the read-data checker is the slave.
interface poc_rddata_checker_if;
  import poc_pkg::*;

  logic              phy_rddata_valid;
  logic [BEAT_W-1:0] phy_rd_data;

  modport master (output phy_rddata_valid, output phy_rd_data);
  modport slave  (input  phy_rddata_valid, input  phy_rd_data);
endinterface

// File: rtl/poc_rdchk_cmp.sv
// Beat compare, stage 1: registers an accepted beat with its index and presents its XOR against PATTERN
// to the stage-2 result registers held in the top.
module poc_rdchk_cmp
  import poc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic              last_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [BEAT_W-1:0] data_i,
  output logic              vld_o,
  output logic              last_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [BEAT_W-1:0] xor_o
);

  logic              vld_q;
  logic              last_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] data_q;

  // NOTE: state is updated with <= so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      vld_q  <= vld_i;
      last_q <= vld_i && last_i;
      if (vld_i) idx_q <= idx_i;
    end
  end

  // NOTE: the wide data register has no reset; vld_q qualifies it, so its power-up value is never observed.
  always_ff @(posedge clk) begin
    if (vld_i) data_q <= data_i;
  end

  assign vld_o  = vld_q;
  assign last_o = last_q;
  assign idx_o  = idx_q;
  assign xor_o  = data_q ^ PATTERN;

endmodule

// File: rtl/poc_rddata_checker.sv
// PoC read-data checker: run FSM, idle timer and result counters around a 2-stage beat compare.
// Define RDCHK_DIFF_MASK_EN to build the sticky per-bit diff_mask accumulator; otherwise diff_mask is 0.
module poc_rddata_checker
  import poc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_calib_complete,
  input  logic                 start,
  poc_rddata_checker_if.slave  rd_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [IDX_W-1:0]     first_err_idx,
  output logic                 first_err_vld,
  output logic [STRAY_W-1:0]   stray_cnt,
  output logic [BEAT_W-1:0]    diff_mask
);

  rdchk_state_e       state_q;
  logic               busy_q, done_q, pass_q, timeout_q;
  logic [CNT_W-1:0]   beat_cnt_q, err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]   first_err_idx_q;
  logic               first_err_vld_q;
  logic [STRAY_W-1:0] stray_cnt_q;
  logic [TMR_W-1:0]   timer_q;

  logic               beat_vld, in_run, arm, accept, last_beat, expire;
  logic               s1_vld, s1_last, beat_mis;
  logic [IDX_W-1:0]   s1_idx;
  logic [BEAT_W-1:0]  s1_xor;

  assign beat_vld  = rd_if.phy_rddata_valid;
  assign in_run    = (state_q == ST_ARMED) || (state_q == ST_CHECK);
  assign arm       = start && init_calib_complete;
  assign accept    = beat_vld && in_run && !arm;
  assign last_beat = accept && (beat_cnt_q == CNT_W'(EXP_BEATS - 1));
  // A beat arriving on the expiry cycle wins: expire requires no valid beat.
  assign expire    = in_run && !arm && !beat_vld && (timer_q == TMR_W'(TIMEOUT_CYCLES));

  poc_rdchk_cmp u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (accept),
    .last_i (last_beat),
    .idx_i  (beat_cnt_q[IDX_W-1:0]),
    .data_i (rd_if.phy_rd_data),
    .vld_o  (s1_vld),
    .last_o (s1_last),
    .idx_o  (s1_idx),
    .xor_o  (s1_xor)
  );

  assign beat_mis  = s1_vld && (|s1_xor);
  assign err_cnt_d = beat_mis ? sat_inc(err_cnt_q) : err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (arm) begin
      state_q   <= ST_ARMED;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_CHECK: begin
          if (last_beat) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else if (accept) begin
            state_q <= ST_CHECK;
          end else if (expire) begin
            state_q   <= ST_TOUT;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
      // done/pass wait for the final compare to retire.
      if (s1_vld && s1_last) begin
        done_q <= 1'b1;
        pass_q <= (err_cnt_d == '0) && (beat_cnt_q == CNT_W'(EXP_BEATS)) && !timeout_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q      <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      stray_cnt_q     <= '0;
      timer_q         <= '0;
    end else begin
      if (beat_vld && !in_run && !(&stray_cnt_q)) stray_cnt_q <= stray_cnt_q + 1'b1;
      if (arm) begin
        beat_cnt_q      <= '0;
        err_cnt_q       <= '0;
        first_err_idx_q <= '0;
        first_err_vld_q <= 1'b0;
        timer_q         <= '0;
      end else begin
        if (accept) beat_cnt_q <= sat_inc(beat_cnt_q);
        err_cnt_q <= err_cnt_d;
        if (beat_mis && !first_err_vld_q) begin
          first_err_vld_q <= 1'b1;
          first_err_idx_q <= s1_idx;
        end
        if (in_run) begin
          if (beat_vld)     timer_q <= '0;
          else if (!expire) timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

`ifdef RDCHK_DIFF_MASK_EN
  logic [BEAT_W-1:0] diff_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        diff_mask_q <= '0;
    else if (arm)      diff_mask_q <= '0;
    else if (beat_mis) diff_mask_q <= diff_mask_q | s1_xor;
  end

  assign diff_mask = diff_mask_q;
`else
  assign diff_mask = '0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign beat_cnt      = beat_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;
  assign stray_cnt     = stray_cnt_q;

endmodule
